// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, requester ids and read-arbiter state type
package core_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam int REQ_FETCH = 0;
    localparam int REQ_LOAD  = 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;
endpackage

// File: rtl/core_rr_arbiter2.sv
// rtl/core_rr_arbiter2.sv - two-way combinational round-robin pick
module core_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       index
);
    always_comb begin
        // A lone requester wins outright; prio only breaks a tie.
        index = (req == 2'b11) ? prio : req[1];
        gnt   = 2'b00;
        if (req != 2'b00) begin
            gnt = index ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/core_axi_read_arbiter.sv
// rtl/core_axi_read_arbiter.sv - fetch/load AXI-lite read-port arbiter with latched address
module core_axi_read_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              S_ARVALID,
    input  logic [2*ADDR_WIDTH-1:0] S_ARADDR,
    output logic [1:0]              S_ARREADY,
    output logic [1:0]              S_RVALID,
    output logic [2*DATA_WIDTH-1:0] S_RDATA,
    input  logic [1:0]              S_RREADY,
    output logic                    M_ARVALID,
    output logic [ADDR_WIDTH-1:0]   M_ARADDR,
    input  logic                    M_ARREADY,
    input  logic                    M_RVALID,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    output logic                    M_RREADY
);
    arb_state_t            state_q;
    logic                  prio_q;
    logic                  grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic [1:0]            gnt;
    logic                  gnt_idx;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  sel_rready;

    core_rr_arbiter2 u_rr (
        .req   (S_ARVALID),
        .prio  (prio_q),
        .gnt   (gnt),
        .index (gnt_idx)
    );

    assign win_addr   = gnt_idx ? S_ARADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : S_ARADDR[ADDR_WIDTH-1:0];
    assign sel_rready = grant_q ? S_RREADY[1] : S_RREADY[0];

    always_comb begin
        S_ARREADY = 2'b00;
        S_RVALID  = 2'b00;
        S_RDATA   = '0;
        M_ARVALID = 1'b0;
        M_ARADDR  = '0;
        M_RREADY  = 1'b0;
        case (state_q)
            ARB_IDLE: S_ARREADY = rst ? 2'b00 : gnt;
            ARB_ADDR: begin
                M_ARVALID = 1'b1;
                M_ARADDR  = addr_q;
            end
            ARB_DATA: begin
                // R channel is a pure pass-through to the granted requester only.
                M_RREADY = sel_rready;
                if (grant_q) begin
                    S_RVALID[1]                        = M_RVALID;
                    S_RDATA[2*DATA_WIDTH-1:DATA_WIDTH] = M_RDATA;
                end else begin
                    S_RVALID[0]              = M_RVALID;
                    S_RDATA[DATA_WIDTH-1:0]  = M_RDATA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            prio_q  <= 1'(REQ_FETCH);
            grant_q <= 1'(REQ_FETCH);
            addr_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (S_ARVALID != 2'b00) begin
                        addr_q  <= win_addr;
                        grant_q <= gnt_idx;
                        state_q <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (M_ARREADY) begin
                        state_q <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (M_RVALID && sel_rready) begin
                        // Favour the other requester on the next tie.
                        prio_q  <= ~grant_q;
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_axi_read_arbiter.sv
// tb/tb_core_axi_read_arbiter.sv - self-checking bench for core_axi_read_arbiter
module tb_core_axi_read_arbiter;
    import core_pkg::*;

    localparam int AW = core_pkg::ADDR_WIDTH;
    localparam int DW = core_pkg::DATA_WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      S_ARVALID;
    logic [2*AW-1:0] S_ARADDR;
    logic [1:0]      S_ARREADY;
    logic [1:0]      S_RVALID;
    logic [2*DW-1:0] S_RDATA;
    logic [1:0]      S_RREADY;
    logic            M_ARVALID;
    logic [AW-1:0]   M_ARADDR;
    logic            M_ARREADY;
    logic            M_RVALID;
    logic [DW-1:0]   M_RDATA;
    logic            M_RREADY;

    int n_cmp = 0;
    int n_err = 0;
    int model_prio = 0;

    core_axi_read_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .S_ARVALID (S_ARVALID),
        .S_ARADDR  (S_ARADDR),
        .S_ARREADY (S_ARREADY),
        .S_RVALID  (S_RVALID),
        .S_RDATA   (S_RDATA),
        .S_RREADY  (S_RREADY),
        .M_ARVALID (M_ARVALID),
        .M_ARADDR  (M_ARADDR),
        .M_ARREADY (M_ARREADY),
        .M_RVALID  (M_RVALID),
        .M_RDATA   (M_RDATA),
        .M_RREADY  (M_RREADY)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        S_ARVALID = 2'b00;
        S_ARADDR  = '0;
        S_RREADY  = 2'b11;
        M_ARREADY = 1'b0;
        M_RVALID  = 1'b0;
        M_RDATA   = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_prio = 0;
    endtask

    // One complete transaction; the winner is derived from the arbitration rules.
    task automatic do_txn(input logic [1:0] valid, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input int ar_dly, input int rv_dly, input int rr_dly,
                          input logic drop, input logic [DW-1:0] data);
        int g;
        logic [AW-1:0] ea;
        logic [1:0] oh;
        logic [DW-1:0] got, other;
        g  = (valid == 2'b11) ? model_prio : ((valid == 2'b10) ? 1 : 0);
        ea = (g == 1) ? a1 : a0;
        oh = (g == 1) ? 2'b10 : 2'b01;
        S_ARVALID = valid;
        S_ARADDR  = {a1, a0};
        M_ARREADY = 1'b0;
        M_RVALID  = 1'b0;
        S_RREADY  = 2'b11;
        #1;
        n_cmp++;
        if (S_ARREADY !== oh || M_ARVALID !== 1'b0) begin
            n_err++;
            $display("FAIL grant: S_ARREADY=%b M_ARVALID=%b required %b/0", S_ARREADY, M_ARVALID, oh);
        end
        step();
        if (drop) begin
            S_ARVALID = 2'b00;
            S_ARADDR  = {$urandom, $urandom};
        end
        for (int i = 0; i <= ar_dly; i++) begin
            M_ARREADY = (i == ar_dly);
            #1;
            n_cmp++;
            if (M_ARVALID !== 1'b1 || M_ARADDR !== ea || S_ARREADY !== 2'b00) begin
                n_err++;
                $display("FAIL addr_phase[%0d]: M_ARVALID=%b M_ARADDR=%h S_ARREADY=%b required 1/%h/00",
                         i, M_ARVALID, M_ARADDR, S_ARREADY, ea);
            end
            step();
        end
        M_ARREADY = 1'b0;
        S_ARVALID = 2'b00;
        for (int i = 0; i < rv_dly; i++) begin
            M_RDATA = $urandom;
            #1;
            n_cmp++;
            if (S_RVALID !== 2'b00 || M_ARVALID !== 1'b0 || S_ARREADY !== 2'b00) begin
                n_err++;
                $display("FAIL data_wait[%0d]: S_RVALID=%b M_ARVALID=%b S_ARREADY=%b required 00/0/00",
                         i, S_RVALID, M_ARVALID, S_ARREADY);
            end
            step();
        end
        for (int i = 0; i <= rr_dly; i++) begin
            M_RVALID = 1'b1;
            M_RDATA  = data;
            S_RREADY[g]     = (i == rr_dly);
            S_RREADY[1 - g] = 1'($urandom);
            #1;
            got   = (g == 1) ? S_RDATA[2*DW-1:DW] : S_RDATA[DW-1:0];
            other = (g == 1) ? S_RDATA[DW-1:0] : S_RDATA[2*DW-1:DW];
            n_cmp++;
            if (S_RVALID !== oh || got !== data || other !== '0 || M_RREADY !== (i == rr_dly)) begin
                n_err++;
                $display("FAIL data_phase[%0d]: S_RVALID=%b data=%h other=%h M_RREADY=%b required %b/%h/0/%b",
                         i, S_RVALID, got, other, M_RREADY, oh, data, (i == rr_dly));
            end
            step();
        end
        M_RVALID = 1'b0;
        S_RREADY = 2'b11;
        model_prio = 1 - g;
    endtask

    task automatic test_reset();
        do_reset();
        M_RVALID = 1'b1;
        M_RDATA  = 32'hdeadbeef;
        #1;
        n_cmp++;
        if (S_ARREADY !== 2'b00 || S_RVALID !== 2'b00 || S_RDATA !== '0 ||
            M_ARVALID !== 1'b0 || M_ARADDR !== '0 || M_RREADY !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: ARREADY=%b RVALID=%b RDATA=%h ARVALID=%b ARADDR=%h RREADY=%b required all 0",
                     S_ARREADY, S_RVALID, S_RDATA, M_ARVALID, M_ARADDR, M_RREADY);
        end
        drive_idle();
        step();
    endtask

    task automatic test_fetch_alone();
        do_reset();
        do_txn(2'b01, 32'h10, 32'h0, 0, 0, 0, 1'b1, 32'h00500093);
        #1;
        n_cmp++;
        if (M_ARVALID !== 1'b0 || S_RVALID !== 2'b00) begin
            n_err++;
            $display("FAIL fetch_back_idle: M_ARVALID=%b S_RVALID=%b required 0/00", M_ARVALID, S_RVALID);
        end
    endtask

    task automatic test_both_valid();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_txn(2'b11, 32'h20, 32'h80, 0, 0, 0, 1'b0, 32'h1000 + k);
        end
    endtask

    task automatic test_arready_stall();
        do_reset();
        do_txn(2'b11, 32'h24, 32'h84, 3, 0, 0, 1'b0, 32'hcafe0001);
        do_txn(2'b11, 32'h28, 32'h88, 3, 1, 0, 1'b0, 32'hcafe0002);
    endtask

    task automatic test_fetch_drop();
        do_reset();
        do_txn(2'b01, 32'h30, 32'h99, 1, 1, 0, 1'b1, 32'h0badf00d);
    endtask

    task automatic test_rready_stall();
        do_reset();
        do_txn(2'b10, 32'h0, 32'h40, 0, 0, 2, 1'b0, 32'h12345678);
    endtask

    task automatic test_reset_in_data();
        do_reset();
        do_txn(2'b01, 32'h50, 32'h0, 0, 0, 0, 1'b0, 32'h11);
        S_ARVALID = 2'b01;
        S_ARADDR  = {32'h0, 32'h54};
        M_ARREADY = 1'b1;
        step();
        S_ARVALID = 2'b00;
        step();
        rst      = 1'b1;
        M_RVALID = 1'b1;
        M_RDATA  = 32'h77;
        S_RREADY = 2'b11;
        M_ARREADY = 1'b0;
        step();
        n_cmp++;
        if (S_ARREADY !== 2'b00 || S_RVALID !== 2'b00 || S_RDATA !== '0 ||
            M_ARVALID !== 1'b0 || M_ARADDR !== '0 || M_RREADY !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_data: ARREADY=%b RVALID=%b RDATA=%h ARVALID=%b ARADDR=%h RREADY=%b required all 0",
                     S_ARREADY, S_RVALID, S_RDATA, M_ARVALID, M_ARADDR, M_RREADY);
        end
        rst      = 1'b0;
        M_RVALID = 1'b0;
        model_prio = 0;
        do_txn(2'b11, 32'h60, 32'h64, 0, 0, 0, 1'b0, 32'h22);
    endtask

    task automatic test_random();
        logic [1:0] v;
        do_reset();
        for (int k = 0; k < 30; k++) begin
            v = 2'($urandom_range(1, 3));
            do_txn(v, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 3), 1'($urandom), $urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_fetch_alone();
        test_both_valid();
        test_arready_stall();
        test_fetch_drop();
        test_rready_stall();
        test_reset_in_data();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
